tree_space_pool_arbiter: RTL and testbench
==========================================

// Module: tree_space_pool_arbiter
// PURPOSE
//  Multi-engine node-address allocator for the tree RAM: NB_ENGINE insert engines request node addresses through a round-robin arbiter.
//  Freed node addresses are recycled through an internal free-list FIFO; a root free reboots the whole address space.
//  Keeps occupancy counters and sticky error flags that the CSR block exposes to the host.
//  Sits between the insert/delete engines and the tree RAM address space.
// PARAMETERS
//  RAM_ADDR_WIDTH  16  node address width in bits
//  NB_ENGINE       2   number of requesting engines, >=1
//  FL_DEPTH_W      8   free-list FIFO depth is 2**FL_DEPTH_W entries
//  LOW_WMARK       4   alloc_low asserts when remaining addresses < LOW_WMARK
// PORTS
//  aclk           in   1                     clock
//  aresetn        in   1                     reset, asynchronous, active-low
//  swrst          in   1                     synchronous soft reset, same effect as aresetn
//  base_addr      in   RAM_ADDR_WIDTH        first allocatable address (CSR)
//  max_addr       in   RAM_ADDR_WIDTH        last allocatable address, inclusive (CSR)
//  req_valid      in   NB_ENGINE             per-engine address request
//  req_ready      out  NB_ENGINE             one-hot grant, at most one bit per cycle
//  req_addr       out  NB_ENGINE*RAM_ADDR_WIDTH  per-engine address, valid while req_ready[i]
//  free_valid     in   1                     address release
//  free_is_root   in   1                     released address is the tree root
//  free_addr      in   RAM_ADDR_WIDTH        address to release
//  free_ready     out  1                     release accepted
//  used_count     out  RAM_ADDR_WIDTH+1      addresses currently allocated
//  alloc_empty    out  1                     no address available (exhausted)
//  alloc_low      out  1                     remaining addresses < LOW_WMARK
//  err_range      out  1                     sticky: free_addr outside [base_addr,max_addr]
//  err_underflow  out  1                     sticky: non-root free while used_count==0
// BEHAVIOUR
//  Reset and swrst: FSM=INIT, counter=base_addr, free list empty, used_count=0, RR pointer=0.
//   All ready outputs are 0 and both error flags are 0 during reset.
//  FSM has three states:
//   INIT: one cycle, loads the counter from base_addr, then goes to RUN.
//   RUN: normal operation.
//   REBOOT: one cycle, entered on an accepted root free; behaves like INIT but also flushes the FIFO and sets used_count=0, then goes to RUN.
//  In INIT and REBOOT, req_ready=0 and free_ready=0.
//  Arbitration (RUN only):
//   Grant the requesting engine at or after the RR pointer, then set the pointer to granted+1 modulo NB_ENGINE.
//   req_ready[i] is combinational from req_valid and is gated by ~alloc_empty.
//   A request is accepted when req_valid[i] and req_ready[i] are both high. Zero-latency, same as the address.
//  Address source: free-list head when the FIFO is non-empty, otherwise the counter. The counter increments only on an accepted request served from the counter.
//  Counter carries one extra MSB; counter_exhausted = counter > max_addr. No wrap-around, the counter saturates at max_addr+1.
//  alloc_empty = FIFO empty AND counter_exhausted.
//  Remaining addresses = FIFO level + (max_addr+1-counter), with the second term clamped at 0; this drives alloc_low.
//  Free path:
//   free_ready = (state==RUN) AND FIFO not full.
//   An accepted non-root, in-range free is pushed to the FIFO.
//   An out-of-range free is accepted and dropped, and sets err_range.
//   An accepted root free is not pushed; the FSM goes to REBOOT on the next cycle.
//  used_count: +1 per accepted request, -1 per accepted in-range non-root free. Same-cycle request and free leave it unchanged.
//   A free while used_count==0 is dropped and sets err_underflow; used_count never underflows.
//  Same-cycle alloc and free with an empty FIFO: the alloc is served from the counter and the freed address is pushed. There is no bypass from free to alloc.
//  Same-cycle root free and grant: the grant completes, then REBOOT discards all state.
//  Sticky errors clear only on aresetn or swrst.
// TESTING
//  Grant order: base=0x10, max=0x13, NB_ENGINE=2, both engines request continuously.
//   -> grants e0,e1,e0,e1 with addresses 0x10,0x11,0x12,0x13.
//   -> then alloc_empty=1, req_ready=0, used_count=4.
//  Recycling: free 0x11 then free 0x12, then request.
//   -> addresses returned 0x11 then 0x12 (FIFO order), used_count back to 4.
//  Root free: after 3 allocations, root free.
//   -> one REBOOT cycle with all ready signals 0.
//   -> next request returns base_addr, used_count=1.
//  Simultaneous events: alloc and free(0x10) in the same cycle with an empty FIFO.
//   -> alloc gets the counter value, used_count unchanged.
//   -> the next alloc returns 0x10.
//  Errors:
//   free 0x50 with max=0x13 -> err_range=1, used_count unchanged.
//   free after reset -> err_underflow=1.
//   both flags stay set until swrst.
//  Full FIFO: FL_DEPTH_W=2, free 4 addresses with no requests.
//   -> free_ready=0 on the 5th free.
//   -> one accepted request restores free_ready=1.

Source files
------------

// File: rtl/tree_space_pool_arbiter_if.sv
// Engine-side bundle of the node-address pool: per-engine allocation requests and the
// shared address release channel.
interface tree_space_pool_arbiter_if #(
    parameter int unsigned RAM_ADDR_WIDTH = 16,
    parameter int unsigned NB_ENGINE      = 2
);
    logic [NB_ENGINE-1:0]                     req_valid;
    logic [NB_ENGINE-1:0]                     req_ready;
    logic [NB_ENGINE-1:0][RAM_ADDR_WIDTH-1:0] req_addr;
    logic                                     free_valid;
    logic                                     free_is_root;
    logic [RAM_ADDR_WIDTH-1:0]                free_addr;
    logic                                     free_ready;

    modport master (
        output req_valid,
        input  req_ready,
        input  req_addr,
        output free_valid,
        output free_is_root,
        output free_addr,
        input  free_ready
    );

    modport slave (
        input  req_valid,
        output req_ready,
        output req_addr,
        input  free_valid,
        input  free_is_root,
        input  free_addr,
        output free_ready
    );
endinterface

// File: rtl/tree_space_pool_arbiter.sv
// Node-address allocator for the tree RAM: round-robin grants to insert engines, recycles
// freed addresses through a free-list FIFO, and reboots the address space on a root free.
module tree_space_pool_arbiter #(
    parameter int unsigned RAM_ADDR_WIDTH = 16,
    parameter int unsigned NB_ENGINE      = 2,
    parameter int unsigned FL_DEPTH_W     = 8,
    parameter int unsigned LOW_WMARK      = 4
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      swrst_i,
    input  logic [RAM_ADDR_WIDTH-1:0] base_addr_i,
    input  logic [RAM_ADDR_WIDTH-1:0] max_addr_i,
    tree_space_pool_arbiter_if.slave  pool_if,
    output logic [RAM_ADDR_WIDTH:0]   used_count_o,
    output logic                      alloc_empty_o,
    output logic                      alloc_low_o,
    output logic                      err_range_o,
    output logic                      err_underflow_o
);
    localparam int unsigned AW      = RAM_ADDR_WIDTH;
    localparam int unsigned CW      = AW + 1;
    localparam int unsigned FlDepth = 2 ** FL_DEPTH_W;
    localparam int unsigned LvlW    = FL_DEPTH_W + 1;
    localparam int unsigned RrW     = (NB_ENGINE > 1) ? $clog2(NB_ENGINE) : 1;
    localparam int unsigned RemW    = ((CW > LvlW) ? CW : LvlW) + 1;

    typedef enum logic [1:0] {StInit, StRun, StReboot} state_e;

    state_e              state_q;
    logic [CW-1:0]       counter_q;
    logic [CW-1:0]       used_q;
    logic [FL_DEPTH_W-1:0] fl_wr_q, fl_rd_q;
    logic [LvlW-1:0]     fl_lvl_q;
    logic [RrW-1:0]      rr_q;
    logic                err_range_q, err_uf_q;
    logic [AW-1:0]       fl_mem_q [FlDepth];

    logic                run, cnt_exhausted, fl_empty, fl_full, alloc_empty;
    logic [CW-1:0]       cnt_eff;
    logic [RemW-1:0]     cnt_left, remaining;
    logic [NB_ENGINE-1:0] grant;
    logic [RrW-1:0]      grant_idx, rr_next;
    logic                found;
    int unsigned         idx;
    logic                accept, from_fifo, free_acc, root_free, in_range;
    logic                fl_push, fl_pop, range_err, underflow;
    logic [AW-1:0]       alloc_addr;

    // While in INIT the counter is logically base_addr, even before it has been loaded.
    assign cnt_eff       = (state_q == StInit) ? {1'b0, base_addr_i} : counter_q;
    assign run           = (state_q == StRun) && !swrst_i;
    assign cnt_exhausted = cnt_eff > {1'b0, max_addr_i};
    assign fl_empty      = (fl_lvl_q == '0);
    assign fl_full       = (fl_lvl_q == LvlW'(FlDepth));
    assign alloc_empty   = fl_empty && cnt_exhausted;
    assign cnt_left      = cnt_exhausted ? '0 :
                           RemW'({1'b0, max_addr_i}) + RemW'(1) - RemW'(cnt_eff);
    assign remaining     = RemW'(fl_lvl_q) + cnt_left;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NB_ENGINE; k++) begin
            idx = (int'(rr_q) + k) % NB_ENGINE;
            if (!found && pool_if.req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = idx[RrW-1:0];
            end
        end
        if (found && run && !alloc_empty) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign rr_next    = (grant_idx == RrW'(NB_ENGINE - 1)) ? '0 : grant_idx + RrW'(1);
    assign accept     = |grant;
    assign from_fifo  = !fl_empty;
    assign alloc_addr = from_fifo ? fl_mem_q[fl_rd_q] : counter_q[AW-1:0];
    assign fl_pop     = accept && from_fifo;

    assign pool_if.req_ready  = grant;
    assign pool_if.req_addr   = {NB_ENGINE{alloc_addr}};
    assign pool_if.free_ready = run && !fl_full;

    assign free_acc  = pool_if.free_valid && pool_if.free_ready;
    assign root_free = free_acc && pool_if.free_is_root;
    assign in_range  = (pool_if.free_addr >= base_addr_i) && (pool_if.free_addr <= max_addr_i);
    assign range_err = free_acc && !pool_if.free_is_root && !in_range;
    assign underflow = free_acc && !pool_if.free_is_root && (used_q == '0);
    assign fl_push   = free_acc && !pool_if.free_is_root && in_range && (used_q != '0);

    always_ff @(posedge aclk) begin
        if (fl_push) begin
            fl_mem_q[fl_wr_q] <= pool_if.free_addr;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= StInit;
            counter_q   <= '0;
            used_q      <= '0;
            fl_wr_q     <= '0;
            fl_rd_q     <= '0;
            fl_lvl_q    <= '0;
            rr_q        <= '0;
            err_range_q <= 1'b0;
            err_uf_q    <= 1'b0;
        end else if (swrst_i) begin
            state_q     <= StInit;
            counter_q   <= {1'b0, base_addr_i};
            used_q      <= '0;
            fl_wr_q     <= '0;
            fl_rd_q     <= '0;
            fl_lvl_q    <= '0;
            rr_q        <= '0;
            err_range_q <= 1'b0;
            err_uf_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StInit: begin
                    counter_q <= {1'b0, base_addr_i};
                    state_q   <= StRun;
                end
                StReboot: begin
                    counter_q <= {1'b0, base_addr_i};
                    used_q    <= '0;
                    fl_wr_q   <= '0;
                    fl_rd_q   <= '0;
                    fl_lvl_q  <= '0;
                    state_q   <= StRun;
                end
                StRun: begin
                    if (accept && !from_fifo) counter_q <= counter_q + CW'(1);
                    if (accept) rr_q <= rr_next;
                    if (fl_push) fl_wr_q <= fl_wr_q + FL_DEPTH_W'(1);
                    if (fl_pop) fl_rd_q <= fl_rd_q + FL_DEPTH_W'(1);
                    unique case ({fl_push, fl_pop})
                        2'b10:   fl_lvl_q <= fl_lvl_q + LvlW'(1);
                        2'b01:   fl_lvl_q <= fl_lvl_q - LvlW'(1);
                        default: fl_lvl_q <= fl_lvl_q;
                    endcase
                    unique case ({accept, fl_push})
                        2'b10:   used_q <= used_q + CW'(1);
                        2'b01:   used_q <= used_q - CW'(1);
                        default: used_q <= used_q;
                    endcase
                    if (range_err) err_range_q <= 1'b1;
                    if (underflow) err_uf_q <= 1'b1;
                    if (root_free) state_q <= StReboot;
                end
                default: state_q <= StInit;
            endcase
        end
    end

    assign used_count_o    = used_q;
    assign alloc_empty_o   = alloc_empty;
    assign alloc_low_o     = remaining < RemW'(LOW_WMARK);
    assign err_range_o     = err_range_q && !swrst_i;
    assign err_underflow_o = err_uf_q && !swrst_i;
endmodule

// File: tb/tb_tree_space_pool_arbiter.sv
// Bench for tree_space_pool_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based model of the allocator.
module tb_tree_space_pool_arbiter;
    localparam int unsigned AW  = 8;
    localparam int unsigned NB  = 2;
    localparam int unsigned FLW = 2;
    localparam int unsigned LW  = 4;
    localparam int          FLD = 4;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          swrst = 1'b0;
    logic [AW-1:0] base_addr, max_addr;
    logic [AW:0]   used_count;
    logic          alloc_empty, alloc_low, err_range, err_underflow;

    tree_space_pool_arbiter_if #(.RAM_ADDR_WIDTH(AW), .NB_ENGINE(NB)) pool_if ();

    tree_space_pool_arbiter #(
        .RAM_ADDR_WIDTH(AW),
        .NB_ENGINE     (NB),
        .FL_DEPTH_W    (FLW),
        .LOW_WMARK     (LW)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .swrst_i        (swrst),
        .base_addr_i    (base_addr),
        .max_addr_i     (max_addr),
        .pool_if        (pool_if.slave),
        .used_count_o   (used_count),
        .alloc_empty_o  (alloc_empty),
        .alloc_low_o    (alloc_low),
        .err_range_o    (err_range),
        .err_underflow_o(err_underflow)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass = 0;

    // Reference model state
    int m_cnt, m_used, m_rr;
    int m_fl[$];
    bit m_blocked, m_reboot, m_erange, m_euf;

    // Last observed outputs, for directed checks
    logic [NB-1:0] o_ready;
    logic [AW-1:0] o_addr;
    logic          o_free_ready, o_empty, o_erange, o_euf;
    int            o_used;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_cnt     = int'(base_addr);
        m_fl.delete();
        m_used    = 0;
        m_rr      = 0;
        m_blocked = 1'b1;
        m_reboot  = 1'b0;
        m_erange  = 1'b0;
        m_euf     = 1'b0;
    endtask

    // Drive one cycle of inputs, compare all outputs with the model, advance the model.
    task automatic step(input logic [NB-1:0] req, input logic fv, input logic root,
                        input int fa, input logic srst);
        int g, exp_addr, left, used0, e;
        bit exhausted, exp_fr, inr;
        pool_if.req_valid    = req;
        pool_if.free_valid   = fv;
        pool_if.free_is_root = root;
        pool_if.free_addr    = AW'(fa);
        swrst                = srst;
        #1;
        o_ready      = pool_if.req_ready;
        o_free_ready = pool_if.free_ready;
        o_used       = int'(used_count);
        o_empty      = alloc_empty;
        o_erange     = err_range;
        o_euf        = err_underflow;
        for (int k = 0; k < NB; k++) if (o_ready[k]) o_addr = pool_if.req_addr[k];
        if (srst) begin
            check("swrst_req_ready", o_ready, 0);
            check("swrst_free_ready", o_free_ready, 0);
            check("swrst_errors", {o_erange, o_euf}, 0);
            model_reset();
        end else begin
            exhausted = m_cnt > int'(max_addr);
            left      = exhausted ? 0 : int'(max_addr) + 1 - m_cnt;
            exp_addr  = (m_fl.size() != 0) ? m_fl[0] : m_cnt;
            g = -1;
            if (!m_blocked && !(m_fl.size() == 0 && exhausted)) begin
                for (int k = 0; k < NB; k++) begin
                    e = (m_rr + k) % NB;
                    if (g < 0 && req[e]) g = e;
                end
            end
            exp_fr = !m_blocked && (m_fl.size() < FLD);
            check("req_ready", o_ready, (g >= 0) ? (1 << g) : 0);
            if (g >= 0) check("req_addr", pool_if.req_addr[g], exp_addr);
            check("free_ready", o_free_ready, exp_fr);
            check("used_count", o_used, m_used);
            check("alloc_empty", o_empty, (m_fl.size() == 0) && exhausted);
            check("alloc_low", alloc_low, (m_fl.size() + left) < LW);
            check("err_range", o_erange, m_erange);
            check("err_underflow", o_euf, m_euf);
            if (m_blocked) begin
                m_cnt = int'(base_addr);
                if (m_reboot) begin
                    m_fl.delete();
                    m_used = 0;
                end
                m_blocked = 1'b0;
                m_reboot  = 1'b0;
            end else begin
                used0 = m_used;
                if (g >= 0) begin
                    if (m_fl.size() != 0) void'(m_fl.pop_front());
                    else m_cnt++;
                    m_rr = (g + 1) % NB;
                    m_used++;
                end
                if (fv && exp_fr) begin
                    if (root) begin
                        m_blocked = 1'b1;
                        m_reboot  = 1'b1;
                    end else begin
                        inr = (fa >= int'(base_addr)) && (fa <= int'(max_addr));
                        if (!inr) m_erange = 1'b1;
                        if (used0 == 0) m_euf = 1'b1;
                        if (inr && used0 != 0) begin
                            m_fl.push_back(fa);
                            m_used--;
                        end
                    end
                end
            end
        end
        @(negedge aclk);
    endtask

    task automatic idle();
        step('0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        int b, lo, hi;
        pool_if.req_valid    = '0;
        pool_if.free_valid   = 1'b0;
        pool_if.free_is_root = 1'b0;
        pool_if.free_addr    = '0;
        base_addr = 8'h10;
        max_addr  = 8'h13;
        repeat (2) @(negedge aclk);
        check("rst_req_ready", pool_if.req_ready, 0);
        check("rst_free_ready", pool_if.free_ready, 0);
        check("rst_used", used_count, 0);
        check("rst_errors", {err_range, err_underflow}, 0);
        aresetn = 1'b1;
        model_reset();
        idle();

        // Grant order and exhaustion
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 1'b0, 1'b0, 0, 1'b0);
            check("grant_order", o_ready, (i % 2 == 1) ? 2 : 1);
            check("grant_addr", o_addr, 32'h10 + i);
        end
        step(2'b11, 1'b0, 1'b0, 0, 1'b0);
        check("exhaust_ready", o_ready, 0);
        check("exhaust_empty", o_empty, 1);
        check("exhaust_used", o_used, 4);

        // Recycling in FIFO order
        step('0, 1'b1, 1'b0, 'h11, 1'b0);
        step('0, 1'b1, 1'b0, 'h12, 1'b0);
        step(2'b01, 1'b0, 1'b0, 0, 1'b0);
        check("recycle_first", o_addr, 'h11);
        step(2'b01, 1'b0, 1'b0, 0, 1'b0);
        check("recycle_second", o_addr, 'h12);
        idle();
        check("recycle_used", o_used, 4);

        // Root free reboots the space
        step('0, 1'b1, 1'b1, 'h10, 1'b0);
        step(2'b11, 1'b1, 1'b0, 'h11, 1'b0);
        check("reboot_req_ready", o_ready, 0);
        check("reboot_free_ready", o_free_ready, 0);
        step(2'b01, 1'b0, 1'b0, 0, 1'b0);
        check("post_reboot_grant", o_ready, 1);
        check("post_reboot_addr", o_addr, 'h10);
        idle();
        check("post_reboot_used", o_used, 1);

        // Same-cycle alloc and free with an empty FIFO
        step(2'b01, 1'b1, 1'b0, 'h10, 1'b0);
        check("simul_addr", o_addr, 'h11);
        step(2'b01, 1'b0, 1'b0, 0, 1'b0);
        check("simul_used", o_used, 1);
        check("simul_next_addr", o_addr, 'h10);

        // Sticky errors
        step('0, 1'b0, 1'b0, 0, 1'b1);
        idle();
        step('0, 1'b1, 1'b0, 'h10, 1'b0);
        idle();
        check("underflow_set", o_euf, 1);
        check("range_still_clear", o_erange, 0);
        step('0, 1'b1, 1'b0, 'h50, 1'b0);
        repeat (3) idle();
        check("range_set", o_erange, 1);
        check("underflow_sticky", o_euf, 1);
        check("error_used", o_used, 0);
        step('0, 1'b0, 1'b0, 0, 1'b1);
        idle();
        check("errors_cleared", {o_erange, o_euf}, 0);

        // Full FIFO backpressure
        for (int i = 0; i < 4; i++) step(2'b01, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) step('0, 1'b1, 1'b0, 'h10 + i, 1'b0);
        step('0, 1'b1, 1'b0, 'h10, 1'b0);
        check("fifo_full_free_ready", o_free_ready, 0);
        step(2'b01, 1'b0, 1'b0, 0, 1'b0);
        idle();
        check("fifo_drain_free_ready", o_free_ready, 1);

        // Randomized traffic over random address windows
        for (int ep = 0; ep < 40; ep++) begin
            b         = $urandom_range(0, 'hF8);
            base_addr = AW'(b);
            hi        = b + $urandom_range(0, 12);
            max_addr  = AW'((hi > 255) ? 255 : hi);
            step('0, 1'b0, 1'b0, 0, 1'b1);
            lo = (b >= 2) ? b - 2 : 0;
            for (int c = 0; c < 60; c++) begin
                step(NB'($urandom), ($urandom_range(0, 9) < 4), ($urandom_range(0, 31) == 0),
                     $urandom_range(lo, int'(max_addr) + 3), 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
